// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants and types for the UART receiver.
//   UART_FULL_ETU     : ETU counter terminal value (bit period = value + 1 clks),
//                       kept identical to the transmitter's setting.
//   UART_HALF_ETU     : mid-bit offset used to qualify the start bit.
//   uart_rx_state_e   : receiver FSM state encodings.
//   shift_in_msb()    : LSB-first deserialiser step (new bit enters at the MSB).
// -----------------------------------------------------------------------------
package uart_rx_pkg;

   localparam int UART_FULL_ETU = 15;
   localparam int UART_HALF_ETU = UART_FULL_ETU / 2;

   typedef enum logic [2:0] {
      UART_RX_IDLE      = 3'd0,
      UART_RX_START     = 3'd1,
      UART_RX_DATA      = 3'd2,
      UART_RX_STOP      = 3'd3,
      UART_RX_WAIT_HIGH = 3'd4
   } uart_rx_state_e;

   // The line carries bit 0 first, so each new sample enters at the top and
   // after eight samples the first one has walked down to bit 0.
   function automatic logic [7:0] shift_in_msb(input logic [7:0] sr,
                                               input logic       bit_i);
      return {bit_i, sr[7:1]};
   endfunction

endpackage : uart_rx_pkg

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for the asynchronous serial line. Both flops preset to
// 1 (line idle level) so a reset never looks like a start bit.
//   clk : system clock (rising edge)
//   rst : synchronous, active-high reset
//   d_i : asynchronous input
//   q_o : synchronized output
// -----------------------------------------------------------------------------
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Synchronizer chain; reset forces the idle (high) level into both stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The line is synchronized, the start bit is qualified at
// its midpoint, then each data bit and the stop bit are sampled one full bit
// period apart. A good stop bit delivers the byte; a bad one pulses frame_err
// and the receiver waits for the line to return high before re-arming.
//
// Parameters
//   FULL_ETU  : ETU counter terminal value; bit period = FULL_ETU+1 clks.
//   HALF_ETU  : start-bit qualification offset.
// Ports
//   clk       : system clock (rising edge)
//   rst       : synchronous, active-high reset
//   din       : asynchronous serial input, idle high
//   ack       : consumer acknowledge; clears valid and overrun
//   data_in   : last received byte
//   valid     : data_in holds an unacknowledged byte
//   busy      : receiver is not idle
//   frame_err : one-cycle pulse on a bad stop bit
//   overrun   : sticky; a byte was overwritten while still unacknowledged
// -----------------------------------------------------------------------------
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int FULL_ETU = UART_FULL_ETU,
   parameter int HALF_ETU = FULL_ETU / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       ack,
   output logic [7:0] data_in,
   output logic       valid,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam logic [8:0] FULL_C = 9'(FULL_ETU);
   localparam logic [8:0] HALF_C = 9'(HALF_ETU);

   logic           rx_s;
   logic           load_s;

   uart_rx_state_e state_q, state_d;
   logic [8:0]     etu_cnt_q, etu_cnt_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     data_q, data_d;
   logic           valid_q, valid_d;
   logic           ferr_q, ferr_d;
   logic           ovr_q, ovr_d;
   logic           busy_q, busy_d;

   uart_sync2 u_sync2 (
      .clk (clk),
      .rst (rst),
      .d_i (din),
      .q_o (rx_s)
   );

   // Receiver FSM: bit timing, deserialisation and stop-bit decision.
   always_comb begin
      state_d   = state_q;
      etu_cnt_d = etu_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      load_s    = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         UART_RX_IDLE: begin
            etu_cnt_d = 9'd0;
            if (rx_s == 1'b0) begin
               state_d = UART_RX_START;
            end else begin
               state_d = UART_RX_IDLE;
            end
         end

         UART_RX_START: begin
            if (etu_cnt_q == HALF_C) begin
               etu_cnt_d = 9'd0;
               if (rx_s == 1'b0) begin
                  bit_cnt_d = 3'd0;
                  state_d   = UART_RX_DATA;
               end else begin
                  // Line went back high before mid-bit: treat as a glitch.
                  state_d   = UART_RX_IDLE;
               end
            end else begin
               etu_cnt_d = etu_cnt_q + 9'd1;
            end
         end

         UART_RX_DATA: begin
            if (etu_cnt_q == FULL_C) begin
               etu_cnt_d = 9'd0;
               shift_d   = shift_in_msb(shift_q, rx_s);
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = UART_RX_STOP;
               end else begin
                  state_d = UART_RX_DATA;
               end
            end else begin
               etu_cnt_d = etu_cnt_q + 9'd1;
            end
         end

         UART_RX_STOP: begin
            if (etu_cnt_q == FULL_C) begin
               etu_cnt_d = 9'd0;
               if (rx_s == 1'b1) begin
                  load_s  = 1'b1;
                  state_d = UART_RX_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = UART_RX_WAIT_HIGH;
               end
            end else begin
               etu_cnt_d = etu_cnt_q + 9'd1;
            end
         end

         UART_RX_WAIT_HIGH: begin
            // A held-low line (break) must not be mistaken for a new start bit.
            etu_cnt_d = 9'd0;
            if (rx_s == 1'b1) begin
               state_d = UART_RX_IDLE;
            end else begin
               state_d = UART_RX_WAIT_HIGH;
            end
         end

         default: begin
            state_d   = UART_RX_IDLE;
            etu_cnt_d = 9'd0;
            bit_cnt_d = 3'd0;
         end
      endcase
   end

   // Consumer-side status: byte delivery, acknowledge and overrun tracking.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;

      if (load_s) begin
         data_d = shift_q;
      end else begin
         data_d = data_q;
      end

      // A new byte wins over an acknowledge landing on the same edge.
      if (load_s) begin
         valid_d = 1'b1;
      end else if (ack) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      // Overrun only when the pending byte was not being taken on this edge.
      if (ack) begin
         ovr_d = 1'b0;
      end else if (load_s && valid_q) begin
         ovr_d = 1'b1;
      end else begin
         ovr_d = ovr_q;
      end

      busy_d = (state_d != UART_RX_IDLE);
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= UART_RX_IDLE;
         etu_cnt_q <= 9'd0;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         etu_cnt_q <= etu_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         busy_q    <= busy_d;
      end
   end

   assign data_in   = data_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 16 clocks per bit (FULL_ETU=15,
// HALF_ETU=7). A timing-level model predicts, per clock edge, when each frame
// completes: the completion edge is 154 edges after the first edge that sees
// the falling start edge on din (2 synchronizer edges + 9 bit periods of 16 +
// HALF_ETU + 1). Outputs are compared against that model on every falling
// edge, and directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int FULL = 15;
   localparam int HALF = 7;
   localparam int BITC = FULL + 1;
   localparam int LAT  = 2 + 9 * BITC + HALF + 1;   // 154

   logic       clk;
   logic       rst;
   logic       din;
   logic       ack;
   logic [7:0] data_in;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   uart_rx #(.FULL_ETU(FULL), .HALF_ETU(HALF)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .ack       (ack),
      .data_in   (data_in),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   bit chk_en   = 1'b0;

   // model state
   int         ev_edge[$];
   bit         ev_good[$];
   logic [7:0] ev_byte[$];
   int         bz_start = 0;
   int         bz_end   = 0;
   logic       m_valid  = 1'b0;
   logic [7:0] m_data   = 8'h00;
   logic       m_ovr    = 1'b0;
   logic       m_ferr   = 1'b0;
   logic       m_busy   = 1'b0;

   int   ferr_cnt   = 0;
   int   valid_rise = -1;
   logic valid_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: frame completions are scheduled events, ack applied
   // by the consumer rules, busy is a known time window per frame.
   always @(posedge clk) begin
      bit         hit;
      bit         good;
      logic [7:0] b;
      edge_n = edge_n + 1;
      hit  = 1'b0;
      good = 1'b0;
      b    = 8'h00;
      if (rst) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_ovr   = 1'b0;
         m_ferr  = 1'b0;
         ev_edge.delete();
         ev_good.delete();
         ev_byte.delete();
      end else begin
         if (ev_edge.size() > 0 && ev_edge[0] == edge_n) begin
            hit  = 1'b1;
            good = ev_good[0];
            b    = ev_byte[0];
            void'(ev_edge.pop_front());
            void'(ev_good.pop_front());
            void'(ev_byte.pop_front());
         end
         m_ferr = hit && !good;
         if (ack) m_ovr = 1'b0;
         else if (hit && good && m_valid) m_ovr = 1'b1;
         if (hit && good) begin
            m_valid = 1'b1;
            m_data  = b;
         end else if (ack) begin
            m_valid = 1'b0;
         end
      end
      m_busy = !rst && (edge_n >= bz_start) && (edge_n < bz_end);
   end

   // Compare process plus small monitors for pulse counting and latency.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid",     {31'd0, valid},     {31'd0, m_valid});
         chk("data_in",   {24'd0, data_in},   {24'd0, m_data});
         chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
         chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
         chk("busy",      {31'd0, busy},      {31'd0, m_busy});
         if (frame_err === 1'b1) ferr_cnt++;
         if (valid === 1'b1 && valid_prev === 1'b0) valid_rise = edge_n;
         valid_prev = valid;
      end
   end

   // Drive one frame, LSB first. A bad frame holds the stop bit low for
   // stop_low cycles before releasing the line.
   task automatic send_frame(input logic [7:0] b, input bit good, input int stop_low);
      int s;
      s = edge_n + 1;
      bz_start = s + 2;
      bz_end   = good ? (s + LAT) : 32'h7fffffff;
      ev_edge.push_back(s + LAT);
      ev_good.push_back(good);
      ev_byte.push_back(b);
      din = 1'b0;
      repeat (BITC) tick;
      for (int i = 0; i < 8; i++) begin
         din = b[i];
         repeat (BITC) tick;
      end
      if (good) begin
         din = 1'b1;
         repeat (BITC) tick;
      end else begin
         din = 1'b0;
         repeat (stop_low) tick;
         bz_end = edge_n + 3;
         din = 1'b1;
         repeat (BITC) tick;
      end
   endtask

   task automatic ack_pulse;
      ack = 1'b1;
      tick;
      ack = 1'b0;
      tick;
   endtask

   initial begin
      int s0;
      int k;
      din = 1'b1;
      ack = 1'b0;
      rst = 1'b1;
      tick;
      chk_en = 1'b1;
      tick;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_data",  {24'd0, data_in}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
      chk("rst_ovr",   {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      repeat (5) tick;

      // good frame 0xA5 and its latency
      s0 = edge_n + 1;
      send_frame(8'hA5, 1'b1, 0);
      chk("a5_data",    {24'd0, data_in}, 32'h000000A5);
      chk("a5_valid",   {31'd0, valid}, 32'd1);
      chk("a5_ferr",    {31'd0, frame_err}, 32'd0);
      chk("a5_ovr",     {31'd0, overrun}, 32'd0);
      chk("a5_latency", valid_rise - s0, 32'd154);
      ack_pulse;
      chk("a5_acked", {31'd0, valid}, 32'd0);

      // 4-cycle glitch on idle line
      ferr_cnt = 0;
      s0 = edge_n + 1;
      bz_start = s0 + 2;
      bz_end   = s0 + 10;
      din = 1'b0;
      repeat (4) tick;
      din = 1'b1;
      k = 0;
      while (busy !== 1'b0 && k < 12) begin
         tick;
         k++;
      end
      chk("glitch_busy_low", {31'd0, busy}, 32'd0);
      repeat (12) tick;
      chk("glitch_valid", {31'd0, valid}, 32'd0);
      chk("glitch_ferr_cnt", ferr_cnt, 32'd0);

      // 0x3C with stop bit held low for 40 cycles
      ferr_cnt = 0;
      send_frame(8'h3C, 1'b0, 40);
      chk("fe_pulses", ferr_cnt, 32'd1);
      chk("fe_valid",  {31'd0, valid}, 32'd0);
      chk("fe_data",   {24'd0, data_in}, 32'h000000A5);
      repeat (4) tick;

      // back-to-back 0x11, 0x22 without ack
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b1, 0);
      chk("ovr_data",  {24'd0, data_in}, 32'h00000022);
      chk("ovr_valid", {31'd0, valid}, 32'd1);
      chk("ovr_flag",  {31'd0, overrun}, 32'd1);
      ack_pulse;
      chk("ovr_ack_valid", {31'd0, valid}, 32'd0);
      chk("ovr_ack_flag",  {31'd0, overrun}, 32'd0);

      // ack coincides with the second load
      s0 = edge_n + 1;
      fork
         begin
            send_frame(8'h33, 1'b1, 0);
            send_frame(8'h44, 1'b1, 0);
         end
         begin
            while (edge_n < s0 + BITC * 10 + LAT - 1) tick;
            ack = 1'b1;
            tick;
            ack = 1'b0;
         end
      join
      chk("coinc_valid", {31'd0, valid}, 32'd1);
      chk("coinc_data",  {24'd0, data_in}, 32'h00000044);
      chk("coinc_ovr",   {31'd0, overrun}, 32'd0);
      ack_pulse;

      // reset in the middle of data bit 4, then a clean 0x5A
      s0 = edge_n + 1;
      bz_start = s0 + 2;
      bz_end   = 32'h7fffffff;
      din = 1'b0;
      repeat (BITC) tick;
      for (int i = 0; i < 4; i++) begin
         din = (8'h96 >> i) & 8'h01;
         repeat (BITC) tick;
      end
      din = 1'b0;
      repeat (8) tick;
      bz_end = edge_n + 1;
      din = 1'b1;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
      chk("mid_rst_valid", {31'd0, valid}, 32'd0);
      chk("mid_rst_data",  {24'd0, data_in}, 32'd0);
      repeat (6) tick;
      send_frame(8'h5A, 1'b1, 0);
      chk("post_rst_data",  {24'd0, data_in}, 32'h0000005A);
      chk("post_rst_valid", {31'd0, valid}, 32'd1);
      chk("post_rst_ovr",   {31'd0, overrun}, 32'd0);
      repeat (4) tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_uart_rx
